// File: rtl/lc3_controller.sv
// LC3 pipeline sequencer: stage enables, memory/control-flow stalls and execute operand bypass.
// Optional stall-cycle counter is built only when LC3_CTRL_PERF_EN is defined.
module lc3_controller #(
    parameter int FILL_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] Instr_dout,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic [1:0]  mem_state,
    output logic [15:0] stall_cycles
);
    localparam int FILL_W = $clog2(FILL_DEPTH + 1);

    localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100, OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {
        MEM_READ     = 2'd0,
        MEM_IND_READ = 2'd1,
        MEM_WRITE    = 2'd2,
        MEM_IDLE     = 2'd3
    } mem_state_t;

    mem_state_t        mem_q, mem_d;
    logic              store_q, store_d;
    logic              pend_q, pend_d;
    logic              stage_q, stage_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [3:0]        fill_en;

    logic [3:0] f_op, id_op, ex_op;
    assign f_op  = Instr_dout[15:12];
    assign id_op = IR[15:12];
    assign ex_op = IR_Exec[15:12];

    logic f_is_ctrl, ex_is_store, ex_is_mem, ex_indirect, ex_alu_prod, ex_mem_prod;
    assign f_is_ctrl   = (f_op == OP_BR) || (f_op == OP_JMP) || (f_op == OP_TRAP);
    assign ex_is_store = (ex_op == OP_ST) || (ex_op == OP_STR) || (ex_op == OP_STI);
    assign ex_mem_prod = (ex_op == OP_LD) || (ex_op == OP_LDR) || (ex_op == OP_LDI);
    assign ex_is_mem   = ex_is_store || ex_mem_prod;
    assign ex_indirect = (ex_op == OP_LDI) || (ex_op == OP_STI);
    assign ex_alu_prod = (ex_op == OP_ADD) || (ex_op == OP_AND) || (ex_op == OP_NOT);

    // Stage gi (fetch, decode, execute, writeback) is live once the fill counter passes gi.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fill
            assign fill_en[gi] = (int'(fill_q) > gi);
        end
    endgenerate

    assign fill_d = (int'(fill_q) < FILL_DEPTH) ? fill_q + FILL_W'(1) : fill_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q   <= MEM_IDLE;
            store_q <= 1'b0;
            pend_q  <= 1'b0;
            stage_q <= 1'b0;
            fill_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            store_q <= store_d;
            pend_q  <= pend_d;
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        enable_updatePC  = 1'b0;
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        br_taken         = 1'b0;
        mem_d            = mem_q;
        store_d          = store_q;
        pend_d           = pend_q;
        stage_d          = stage_q;
        if (mem_q != MEM_IDLE) begin
            // Only the final read of a load retires into the register file.
            enable_writeback = (mem_q == MEM_READ) && complete_data;
            if (complete_data) begin
                if (mem_q == MEM_IND_READ) begin
                    mem_d = store_q ? MEM_WRITE : MEM_READ;
                end else begin
                    mem_d = MEM_IDLE;
                end
            end
        end else if (complete_instr) begin
            enable_decode    = fill_en[1];
            enable_execute   = fill_en[2];
            enable_writeback = fill_en[3];
            if (pend_q) begin
                // stage_q marks the control instruction having reached IR_Exec.
                if (stage_q) begin
                    enable_updatePC = 1'b1;
                    br_taken        = (ex_op == OP_BR) ? |(NZP & psr) : 1'b1;
                    pend_d          = 1'b0;
                    stage_d         = 1'b0;
                end else begin
                    stage_d = 1'b1;
                end
            end else begin
                enable_updatePC = fill_en[0];
                enable_fetch    = fill_en[0];
                if (fill_en[0] && f_is_ctrl) begin
                    pend_d  = 1'b1;
                    stage_d = 1'b0;
                end
            end
            if (enable_execute && ex_is_mem) begin
                store_d = ex_is_store;
                mem_d   = ex_indirect ? MEM_IND_READ : (ex_is_store ? MEM_WRITE : MEM_READ);
            end
        end
    end

    assign mem_state = mem_q;

    logic [2:0] ex_dst;
    logic       src1_match, src2_match;
    assign ex_dst     = IR_Exec[11:9];
    assign src1_match = (IR[8:6] == ex_dst) &&
                        ((id_op == OP_ADD) || (id_op == OP_AND) || (id_op == OP_NOT) ||
                         (id_op == OP_LDR) || (id_op == OP_STR) || (id_op == OP_JMP));
    // Operand 2 carries either the register source of ADD/AND or the store data register.
    assign src2_match = ((IR[2:0] == ex_dst) && ((id_op == OP_ADD) || (id_op == OP_AND)) && !IR[5]) ||
                        ((IR[11:9] == ex_dst) &&
                         ((id_op == OP_ST) || (id_op == OP_STR) || (id_op == OP_STI)));

    assign bypass_alu_1 = enable_execute && src1_match && ex_alu_prod;
    assign bypass_alu_2 = enable_execute && src2_match && ex_alu_prod;
    assign bypass_mem_1 = enable_execute && src1_match && ex_mem_prod;
    assign bypass_mem_2 = enable_execute && src2_match && ex_mem_prod;

`ifdef LC3_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;
    assign stall_d = ((int'(fill_q) == FILL_DEPTH) && !enable_fetch && (stall_q != 16'hFFFF))
                     ? stall_q + 16'd1 : stall_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

    logic unused_bits;
    assign unused_bits = ^{Instr_dout[11:0], IR[4:3], IR_Exec[8:0]};
endmodule
